hazard_unit: RTL
================

// Module: hazard_unit
// PURPOSE
//  Interlock controller for the 5-stage pipeline; the stall/flush half of
//  hazard resolution (the forwarding unit handles bypassing). Detects load-use
//  hazards between the ID instruction and a load in EX. Flushes wrong-path
//  instructions when a branch resolves taken in EX. Freezes the pipeline while
//  data memory is busy. Keeps saturating stall/flush performance counters.
// PARAMETERS
//  CNT_W        16  width of the performance counters
//  MEM_TIMEOUT  15  max memory-busy cycles before timeout (1..2^TO_W-1)
//  TO_W          4  width of the memory-wait counter
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous active-low reset
//  op_code_ID     in   6      opcode of instruction in ID (codes from defines.v)
//  rs_ID, rt_ID   in   5      source register fields in ID
//  mem_read_EX    in   1      EX instruction is a load
//  dest_EX        in   5      destination register of EX instruction
//  branch_taken_EX in  1      branch/jump in EX resolved taken
//  mem_req_MEM    in   1      MEM stage is issuing a data-memory access
//  mem_ready      in   1      data memory completes access this cycle
//  pc_write       out  1      1 = PC may update
//  if_id_write    out  1      1 = IF/ID register may load
//  id_ex_bubble   out  1      1 = load NOP into ID/EX (load-use bubble)
//  if_id_flush    out  1      1 = clear IF/ID (wrong path)
//  id_ex_flush    out  1      1 = clear ID/EX (wrong path)
//  pipe_freeze    out  1      1 = hold EX/MEM and MEM/WB, suppress WB write
//  mem_timeout    out  1      sticky error: memory exceeded MEM_TIMEOUT
//  stall_cnt      out  CNT_W  load-use stall cycles, saturating
//  flush_cnt      out  CNT_W  taken-branch flushes, saturating
// BEHAVIOUR
//  Reset: state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
//  Outputs in reset: pc_write=1, if_id_write=1, all other 1-bit outputs 0.
//  Source use in ID: uses_rs = all opcodes except OP_J.
//   uses_rt = OP_ADD, OP_SUB, OP_SW, OP_BEQ, OP_BNE.
//  lu_haz = mem_read_EX && dest_EX!=0 && ((uses_rs && dest_EX==rs_ID) ||
//   (uses_rt && dest_EX==rt_ID)); combinational, same cycle.
//  mem_busy = mem_req_MEM && !mem_ready.
//  FSM (registered state, combinational outputs):
//   RUN: mem_busy -> WAIT (freeze asserted this cycle already, wait_cnt=1).
//    Else if branch_taken_EX -> if_id_flush=id_ex_flush=1, flush_cnt++.
//    Else if lu_haz -> pc_write=0, if_id_write=0, id_ex_bubble=1, stall_cnt++.
//   WAIT: pipe_freeze=1, pc_write=0, if_id_write=0; no flush or bubble.
//    wait_cnt++ each cycle. mem_ready -> RUN (freeze still 1 this cycle).
//    In the next RUN cycle, a still-asserted branch/lu_haz is handled normally.
//    wait_cnt==MEM_TIMEOUT && !mem_ready -> ERR.
//   ERR: pipe_freeze=1, pc_write=0, if_id_write=0, mem_timeout=1; leaves only
//    by reset.
//  Priority: freeze > branch flush > load-use stall.
//   Taken branch plus lu_haz in one cycle: flush only; no stall is counted.
//  Counters saturate at all-ones; they increment only on the cycle the action
//   is asserted.
//  Reset mid-WAIT or in ERR: immediate return to reset values, no glitch
//   requirement on outputs during reset.
//  rs/rt == 0 never causes a stall (register 0 has no producer).
// STRUCTURE
//  Opcodes (OP_ADD, OP_SUB, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_J) come from
//   defines.v; add state encodings HZ_RUN/HZ_WAIT/HZ_ERR (2 bits) there.
//  One sub-module: sat_counter #(W) (en, clk, rst_n, q), instantiated for
//   stall_cnt and flush_cnt.
//  Detection logic and FSM stay in hazard_unit.
// TESTING
//  1. LW r5 in EX (mem_read_EX=1, dest_EX=5), ADD rs=5 in ID -> 1 cycle:
//     pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt 0->1.
//  2. LW dest_EX=0, ID rs=0 -> no stall. J with rs field=5 after LW r5 -> no
//     stall. SW rt=5 after LW r5 -> stall.
//  3. branch_taken_EX=1 with lu_haz=1 -> if_id_flush=id_ex_flush=1,
//     id_ex_bubble=0; flush_cnt+1, stall_cnt unchanged.
//  4. mem_req_MEM=1, mem_ready low 3 cycles then high -> pipe_freeze=1 for 4
//     cycles, then RUN; pending branch_taken_EX flushes on the first RUN cycle.
//  5. mem_ready held low 20 cycles (MEM_TIMEOUT=15) -> ERR after 15 busy
//     cycles, mem_timeout=1 sticky; assert rst_n=0 mid-ERR -> all reset values.
//  6. Force 2^CNT_W+3 load-use stalls (CNT_W=4 build) -> stall_cnt holds 4'hF.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline interlock controller: opcode
// encodings, interlock FSM state encodings and source-operand decoding.
package hazard_unit_pkg;

    localparam logic [5:0] OP_ADD = 6'h01;
    localparam logic [5:0] OP_SUB = 6'h03;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        HZ_RUN  = 2'd0,
        HZ_WAIT = 2'd1,
        HZ_ERR  = 2'd2
    } hz_state_e;

    // Every instruction except an absolute jump reads rs.
    function automatic logic uses_rs(input logic [5:0] op);
        return (op != OP_J);
    endfunction

    // Only register-register ALU ops, stores and compare-branches read rt.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of pipeline-stage inputs and interlock control outputs exchanged
// between the pipeline datapath (master) and the hazard unit (slave).
interface hazard_unit_if #(
    parameter int CNT_W = 16
) ();

    logic [5:0]       op_code_ID;
    logic [4:0]       rs_ID;
    logic [4:0]       rt_ID;
    logic             mem_read_EX;
    logic [4:0]       dest_EX;
    logic             branch_taken_EX;
    logic             mem_req_MEM;
    logic             mem_ready;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pipe_freeze;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output op_code_ID, rs_ID, rt_ID, mem_read_EX, dest_EX,
               branch_taken_EX, mem_req_MEM, mem_ready,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
               pipe_freeze, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  op_code_ID, rs_ID, rt_ID, mem_read_EX, dest_EX,
               branch_taken_EX, mem_req_MEM, mem_ready,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
               pipe_freeze, mem_timeout, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         en,
    input  logic         clk,
    input  logic         rst_n,
    output logic [W-1:0] q
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + W'(1);
    endfunction

    // Count one event per enabled cycle, holding once saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= sat_inc(q);
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush interlock controller for the 5-stage pipeline: load-use
// bubbles, wrong-path flushes on taken branches, and a pipeline freeze while
// data memory is busy, with a sticky timeout if memory never answers.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_unit_if.slave hz
);

    localparam logic [TO_W-1:0] WAIT_LIMIT = TO_W'(MEM_TIMEOUT);

    hz_state_e       state_q, state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;

    logic lu_haz;
    logic mem_busy;
    logic stall_en;
    logic flush_en;

    logic pc_write_c;
    logic if_id_write_c;
    logic id_ex_bubble_c;
    logic if_id_flush_c;
    logic id_ex_flush_c;
    logic pipe_freeze_c;
    logic mem_timeout_c;

    // Hazard detection: the load in EX writes a register the ID instruction
    // reads. Register 0 is never produced, so dest_EX==0 can never match.
    always_comb begin
        lu_haz   = hz.mem_read_EX && (hz.dest_EX != 5'd0) &&
                   ((uses_rs(hz.op_code_ID) && (hz.dest_EX == hz.rs_ID)) ||
                    (uses_rt(hz.op_code_ID) && (hz.dest_EX == hz.rt_ID)));
        mem_busy = hz.mem_req_MEM && !hz.mem_ready;
    end

    // Next state and interlock outputs; priority is freeze > flush > stall.
    // Outputs are held at their idle values while reset is asserted.
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        pc_write_c     = 1'b1;
        if_id_write_c  = 1'b1;
        id_ex_bubble_c = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        pipe_freeze_c  = 1'b0;
        mem_timeout_c  = 1'b0;
        stall_en       = 1'b0;
        flush_en       = 1'b0;
        if (rst_n) begin
            case (state_q)
                HZ_RUN: begin
                    if (mem_busy) begin
                        state_d       = HZ_WAIT;
                        wait_cnt_d    = TO_W'(1);
                        pipe_freeze_c = 1'b1;
                        pc_write_c    = 1'b0;
                        if_id_write_c = 1'b0;
                    end else begin
                        wait_cnt_d = '0;
                        if (hz.branch_taken_EX) begin
                            if_id_flush_c = 1'b1;
                            id_ex_flush_c = 1'b1;
                            flush_en      = 1'b1;
                        end else if (lu_haz) begin
                            pc_write_c     = 1'b0;
                            if_id_write_c  = 1'b0;
                            id_ex_bubble_c = 1'b1;
                            stall_en       = 1'b1;
                        end
                    end
                end
                HZ_WAIT: begin
                    pipe_freeze_c = 1'b1;
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    if (hz.mem_ready) begin
                        state_d    = HZ_RUN;
                        wait_cnt_d = wait_cnt_q + TO_W'(1);
                    end else if (wait_cnt_q == WAIT_LIMIT) begin
                        state_d = HZ_ERR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + TO_W'(1);
                    end
                end
                HZ_ERR: begin
                    pipe_freeze_c = 1'b1;
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    mem_timeout_c = 1'b1;
                end
                default: begin
                    // Unused encoding: fall back to normal operation.
                    state_d    = HZ_RUN;
                    wait_cnt_d = '0;
                end
            endcase
        end
    end

    // FSM state and memory-wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HZ_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Drive the interface outputs from the combinational decisions.
    always_comb begin
        hz.pc_write     = pc_write_c;
        hz.if_id_write  = if_id_write_c;
        hz.id_ex_bubble = id_ex_bubble_c;
        hz.if_id_flush  = if_id_flush_c;
        hz.id_ex_flush  = id_ex_flush_c;
        hz.pipe_freeze  = pipe_freeze_c;
        hz.mem_timeout  = mem_timeout_c;
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .en    (stall_en),
        .clk   (clk),
        .rst_n (rst_n),
        .q     (hz.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .en    (flush_en),
        .clk   (clk),
        .rst_n (rst_n),
        .q     (hz.flush_cnt)
    );

endmodule
